lab4_buffer_readout: RTL

//  Read-side sequencer for the LAB4 sample buffer. Takes a (start address, word count) request.

---
 rtl/lab4_pkg.sv | 21 ++
 rtl/lab4_rdout_fifo.sv | 51 +++++
 rtl/lab4_buffer_readout.sv | 108 ++++++++++
 3 files changed

// File: rtl/lab4_pkg.sv
// Shared types and helpers for the LAB4 buffer readout path.
package lab4_pkg;

  localparam int LAB4_SAMPLE_WIDTH = 12;
  localparam int LAB4_BUF_WORDS    = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lab4_state_e;

  // Keeps the two 12-bit samples in place and clears the pad nibbles above each.
  function automatic logic [31:0] lab4_pack_word(input logic [31:0] raw);
    logic [15:0] half_mask;
    half_mask = {{(16 - LAB4_SAMPLE_WIDTH){1'b0}}, {LAB4_SAMPLE_WIDTH{1'b1}}};
    return raw & {half_mask, half_mask};
  endfunction

endpackage

// File: rtl/lab4_rdout_fifo.sv
// Output skid FIFO for the readout stream: data+last per entry, head held in flops.
module lab4_rdout_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/lab4_buffer_readout.sv
// Read-side sequencer for the LAB4 sample buffer: issues credit-limited reads and
// streams the masked words out with a last flag.
module lab4_buffer_readout
  import lab4_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(LAB4_BUF_WORDS),
  parameter int LEN_WIDTH  = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  buf_en_o,
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  input  logic [31:0]           buf_data_i,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  lab4_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [ADDR_WIDTH-1:0]      addr_hold_q;
  logic [LEN_WIDTH-1:0]       rem_q;
  logic                       rd_pending_q;
  logic                       last_pending_q;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [32:0]                fifo_out;
  logic                       accept;
  logic                       credit_ok;
  logic                       issue;
  logic                       pop;

  assign accept    = (state_q == IDLE) && start_i;
  // Reads still in flight count against FIFO space so a stalled sink cannot overflow it.
  assign credit_ok = (32'(fifo_count) + 32'(rd_pending_q)) < 32'(FIFO_DEPTH);
  assign issue     = (state_q == READ) && credit_ok;
  assign pop       = m_tvalid && m_tready;

  assign buf_en_o   = issue;
  // addr_q already points past the last issued word, so show the held copy while idle.
  assign buf_addr_o = issue ? addr_q : addr_hold_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign m_tdata    = fifo_out[31:0];
  assign m_tlast    = fifo_out[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (num_words_i == '0) ? DONE : READ;
      READ:    if (issue && (rem_q == LEN_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   if (pop && m_tlast) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      addr_hold_q    <= '0;
      rem_q          <= '0;
      rd_pending_q   <= 1'b0;
      last_pending_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= start_addr_i;
        rem_q  <= num_words_i;
      end else if (issue) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        rem_q       <= rem_q - LEN_WIDTH'(1);
        addr_hold_q <= addr_q;
      end
      rd_pending_q   <= issue;
      last_pending_q <= issue && (rem_q == LEN_WIDTH'(1));
    end
  end

  lab4_rdout_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending_q),
    .push_data ({last_pending_q, lab4_pack_word(buf_data_i)}),
    .pop       (pop),
    .out_data  (fifo_out),
    .out_valid (m_tvalid),
    .count     (fifo_count)
  );

endmodule
